// File: rtl/storage_read_arbiter.sv
// Round-robin arbiter for the single storageMgmt read port, with a held
// registered response per grant and a pass-through write port that bypasses
// same-cycle write data into a colliding read.
module storage_read_arbiter #(
    parameter int unsigned READ_ADDR_SIZE = 28,
    parameter int unsigned ROW_WIDTH      = 32,
    parameter int unsigned AMT_READER     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 startSig,
    input  logic [READ_ADDR_SIZE*AMT_READER-1:0] reqAddrs,
    input  logic [AMT_READER-1:0]                reqValid,
    output logic [AMT_READER-1:0]                reqReady,
    output logic [AMT_READER-1:0]                rspValid,
    output logic [ROW_WIDTH-1:0]                 rspData,
    input  logic [AMT_READER-1:0]                rspReady,
    input  logic                                 wrEn,
    input  logic [READ_ADDR_SIZE-1:0]            wrAddr,
    input  logic [ROW_WIDTH-1:0]                 wrData,
    output logic [READ_ADDR_SIZE*AMT_READER-1:0] memReadAddrs,
    output logic [AMT_READER-1:0]                memReadEns,
    input  logic [ROW_WIDTH-1:0]                 memReadData,
    output logic [READ_ADDR_SIZE-1:0]            memWriteAddr,
    output logic [ROW_WIDTH-1:0]                 memWriteData,
    output logic                                 memWriteEn
);

    localparam int unsigned IDX_W = (AMT_READER > 1) ? $clog2(AMT_READER) : 1;
    localparam logic [IDX_W:0]   AMT_N = (IDX_W+1)'(AMT_READER);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(AMT_READER - 1);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARB      = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          p;
    logic [IDX_W-1:0]          owner;

    logic                      found_c;
    logic [IDX_W-1:0]          win_c;
    logic [IDX_W:0]            scan_c;
    logic [READ_ADDR_SIZE-1:0] win_addr_c;
    logic                      release_c;
    logic                      grant_c;
    logic                      bypass_c;
    logic [IDX_W-1:0]          next_p_c;

    // First valid requester at or above the pointer, wrapping modulo AMT_READER.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        scan_c  = '0;
        for (int unsigned k = 0; k < AMT_READER; k++) begin
            scan_c = {1'b0, p} + (IDX_W+1)'(k);
            if (scan_c >= AMT_N) begin
                scan_c = scan_c - AMT_N;
            end
            if (!found_c && reqValid[scan_c[IDX_W-1:0]]) begin
                found_c = 1'b1;
                win_c   = scan_c[IDX_W-1:0];
            end
        end
    end

    // Address of the winning requester.
    always_comb begin
        win_addr_c = '0;
        for (int unsigned k = 0; k < AMT_READER; k++) begin
            if (win_c == IDX_W'(k)) begin
                win_addr_c = reqAddrs[k*READ_ADDR_SIZE +: READ_ADDR_SIZE];
            end
        end
    end

    // A grant may happen in ARB, or in HOLD in the same cycle the owner releases.
    assign release_c = (state == HOLD) && rspReady[owner];
    assign grant_c   = found_c && ((state == ARB) || release_c);
    assign bypass_c  = wrEn && (wrAddr == win_addr_c);
    assign next_p_c  = (win_c == LAST) ? '0 : win_c + 1'b1;

    // Grant handshake and storage port drive; only read slot 0 is used.
    always_comb begin
        reqReady     = '0;
        memReadEns   = '0;
        memReadAddrs = '0;
        for (int unsigned k = 0; k < AMT_READER; k++) begin
            reqReady[k] = grant_c && (win_c == IDX_W'(k));
        end
        memReadEns[0] = grant_c;
        if (grant_c) begin
            memReadAddrs[READ_ADDR_SIZE-1:0] = win_addr_c;
        end
    end

    // Writer is forwarded untouched whenever the block is enabled.
    assign memWriteAddr = wrAddr;
    assign memWriteData = wrData;
    assign memWriteEn   = wrEn && (state != DISABLED);

    // Sequencer: enable, capture the granted read, hold until released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DISABLED;
            p        <= '0;
            owner    <= '0;
            rspValid <= '0;
            rspData  <= '0;
        end else begin
            unique case (state)
                DISABLED: begin
                    if (startSig) begin
                        state <= ARB;
                    end
                end
                ARB, HOLD: begin
                    if (grant_c) begin
                        rspData  <= bypass_c ? wrData : memReadData;
                        rspValid <= reqReady;
                        owner    <= win_c;
                        p        <= next_p_c;
                        state    <= HOLD;
                    end else if (release_c) begin
                        rspValid <= '0;
                        state    <= ARB;
                    end
                end
                default: begin
                    state <= DISABLED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_storage_read_arbiter.sv
// Directed bench for storage_read_arbiter: a 2-reader instance backed by a
// small storage model, plus a 3-reader instance for pointer wrap-around.
module tb_storage_read_arbiter;

    localparam int unsigned A = 28;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           startSig;
    logic [2*A-1:0] reqAddrs;
    logic [1:0]     reqValid;
    logic [1:0]     reqReady;
    logic [1:0]     rspValid;
    logic [W-1:0]   rspData;
    logic [1:0]     rspReady;
    logic           wrEn;
    logic [A-1:0]   wrAddr;
    logic [W-1:0]   wrData;
    logic [2*A-1:0] memReadAddrs;
    logic [1:0]     memReadEns;
    logic [W-1:0]   memReadData;
    logic [A-1:0]   memWriteAddr;
    logic [W-1:0]   memWriteData;
    logic           memWriteEn;

    logic [3*A-1:0] r3Addrs;
    logic [2:0]     r3Valid;
    logic [2:0]     r3Ready;
    logic [2:0]     s3Valid;
    logic [W-1:0]   s3Data;
    logic [2:0]     s3Ready;
    logic           w3En;
    logic [3*A-1:0] m3Addrs;
    logic [2:0]     m3Ens;
    logic [W-1:0]   m3Data;
    logic [A-1:0]   m3WrAddr;
    logic [W-1:0]   m3WrData;
    logic           m3WrEn;

    storage_read_arbiter #(.READ_ADDR_SIZE(A), .ROW_WIDTH(W), .AMT_READER(2)) u_dut (
        .clk(clk), .rst(rst), .startSig(startSig),
        .reqAddrs(reqAddrs), .reqValid(reqValid), .reqReady(reqReady),
        .rspValid(rspValid), .rspData(rspData), .rspReady(rspReady),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .memReadAddrs(memReadAddrs), .memReadEns(memReadEns), .memReadData(memReadData),
        .memWriteAddr(memWriteAddr), .memWriteData(memWriteData), .memWriteEn(memWriteEn)
    );

    storage_read_arbiter #(.READ_ADDR_SIZE(A), .ROW_WIDTH(W), .AMT_READER(3)) u_dut3 (
        .clk(clk), .rst(rst), .startSig(startSig),
        .reqAddrs(r3Addrs), .reqValid(r3Valid), .reqReady(r3Ready),
        .rspValid(s3Valid), .rspData(s3Data), .rspReady(s3Ready),
        .wrEn(w3En), .wrAddr(wrAddr), .wrData(wrData),
        .memReadAddrs(m3Addrs), .memReadEns(m3Ens), .memReadData(m3Data),
        .memWriteAddr(m3WrAddr), .memWriteData(m3WrData), .memWriteEn(m3WrEn)
    );

    // Storage model: default row = 0x1000_0000 + addr, writes land on the edge.
    logic [W-1:0] mem [256];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (memWriteEn) begin
            mem[memWriteAddr[7:0]] <= memWriteData;
        end
    end
    assign memReadData = mem[memReadAddrs[7:0]];

    // Three-reader storage returns a pattern derived from the address.
    assign m3Data = {4'h5, m3Addrs[A-1:0]};

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0; startSig = 1'b0; reqAddrs = '0; reqValid = '0; rspReady = '0;
        wrEn = 1'b1; wrAddr = 28'd7; wrData = 32'h0000_0BAD;
        r3Addrs = '0; r3Valid = '0; s3Ready = '0; w3En = 1'b0;
        #1;
        chk("rst_reqReady", 128'(reqReady), 128'(2'b00));
        chk("rst_rspValid", 128'(rspValid), 128'(2'b00));
        chk("rst_rspData", 128'(rspData), 128'(32'h0));
        chk("rst_memReadEns", 128'(memReadEns), 128'(2'b00));
        chk("rst_memWriteEn", 128'(memWriteEn), 128'(1'b0));

        // Disabled: requests and writes are ignored.
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); reqValid = 2'b01; reqAddrs = {28'd0, 28'd3}; #1;
            chk("dis_reqReady", 128'(reqReady), 128'(2'b00));
            chk("dis_rspValid", 128'(rspValid), 128'(2'b00));
            chk("dis_memWriteEn", 128'(memWriteEn), 128'(1'b0));
        end

        @(negedge clk); reqValid = 2'b00; wrEn = 1'b0; startSig = 1'b1; #1;
        chk("start_reqReady", 128'(reqReady), 128'(2'b00));

        // Preload mem[5] through the forwarded write port.
        @(negedge clk); startSig = 1'b0; wrEn = 1'b1; wrAddr = 28'd5; wrData = 32'hDEAD_BEEF; #1;
        chk("pre_memWriteEn", 128'(memWriteEn), 128'(1'b1));
        chk("pre_memReadEns", 128'(memReadEns), 128'(2'b00));
        chk("pre_reqReady", 128'(reqReady), 128'(2'b00));

        // Both requesting, both always ready: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); wrEn = 1'b0; reqValid = 2'b11; rspReady = 2'b11;
            reqAddrs = {28'd4, 28'd3}; #1;
            chk("alt_reqReady", 128'(reqReady), (i % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
            chk("alt_memReadEns", 128'(memReadEns), 128'(2'b01));
            chk("alt_memReadAddr", 128'(memReadAddrs),
                (i % 2 == 0) ? 128'(56'd3) : 128'(56'd4));
            if (i > 0) begin
                chk("alt_rspValid", 128'(rspValid), (i % 2 == 1) ? 128'(2'b01) : 128'(2'b10));
                chk("alt_rspData", 128'(rspData),
                    (i % 2 == 1) ? 128'(32'h1000_0003) : 128'(32'h1000_0004));
            end
        end

        // Release owner 1 and regrant requester 1 at address 5.
        @(negedge clk); reqValid = 2'b10; reqAddrs = {28'd5, 28'd3}; rspReady = 2'b11; #1;
        chk("re1_reqReady", 128'(reqReady), 128'(2'b10));
        chk("re1_rspData", 128'(rspData), 128'(32'h1000_0004));

        // Stalled owner 1: response held, requester 0 blocked, write ignored by snapshot.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); reqValid = 2'b01; rspReady = 2'b01;
            wrEn = (i == 0); wrAddr = 28'd5; wrData = 32'h0000_0001; #1;
            chk("stall_reqReady", 128'(reqReady), 128'(2'b00));
            chk("stall_rspValid", 128'(rspValid), 128'(2'b10));
            chk("stall_rspData", 128'(rspData), 128'(32'hDEAD_BEEF));
        end

        @(negedge clk); wrEn = 1'b0; reqValid = 2'b01; rspReady = 2'b10; #1;
        chk("rel_reqReady", 128'(reqReady), 128'(2'b01));
        chk("rel_rspData", 128'(rspData), 128'(32'hDEAD_BEEF));

        // Same-cycle write and read of address 9: bypass.
        @(negedge clk); reqValid = 2'b01; reqAddrs = {28'd5, 28'd9}; rspReady = 2'b01;
        wrEn = 1'b1; wrAddr = 28'd9; wrData = 32'hA5A5_A5A5; #1;
        chk("byp_reqReady", 128'(reqReady), 128'(2'b01));
        chk("byp_prev_rspData", 128'(rspData), 128'(32'h1000_0003));

        // Read address 5: the write issued during the stall landed in storage.
        @(negedge clk); wrEn = 1'b0; reqValid = 2'b10; rspReady = 2'b01; #1;
        chk("byp_rspData", 128'(rspData), 128'(32'hA5A5_A5A5));
        chk("rd5_reqReady", 128'(reqReady), 128'(2'b10));

        // Read address 7: the write offered while disabled never reached storage.
        @(negedge clk); reqValid = 2'b01; reqAddrs = {28'd5, 28'd7}; rspReady = 2'b10; #1;
        chk("rd5_rspData", 128'(rspData), 128'(32'h0000_0001));
        chk("rd7_reqReady", 128'(reqReady), 128'(2'b01));

        // Release with no requests: back to idle arbitration.
        @(negedge clk); reqValid = 2'b00; rspReady = 2'b01; #1;
        chk("rd7_rspData", 128'(rspData), 128'(32'h1000_0007));
        chk("idle_reqReady", 128'(reqReady), 128'(2'b00));
        chk("idle_memReadEns", 128'(memReadEns), 128'(2'b00));

        @(negedge clk); rspReady = 2'b00; #1;
        chk("idle_rspValid", 128'(rspValid), 128'(2'b00));

        // Asynchronous reset while holding a response for requester 1.
        @(negedge clk); reqValid = 2'b10; reqAddrs = {28'd4, 28'd3}; #1;
        chk("hold_reqReady", 128'(reqReady), 128'(2'b10));
        @(negedge clk); reqValid = 2'b00; #1;
        chk("hold_rspValid", 128'(rspValid), 128'(2'b10));
        #2 rst = 1'b0; #1;
        chk("arst_rspValid", 128'(rspValid), 128'(2'b00));
        chk("arst_rspData", 128'(rspData), 128'(32'h0));

        @(negedge clk); rst = 1'b1; reqValid = 2'b01; #1;
        chk("post_rst_disabled", 128'(reqReady), 128'(2'b00));
        @(negedge clk); startSig = 1'b1; #1;
        chk("post_rst_start", 128'(reqReady), 128'(2'b00));
        @(negedge clk); startSig = 1'b0; reqValid = 2'b11; rspReady = 2'b11; #1;
        chk("post_rst_ptr0", 128'(reqReady), 128'(2'b01));

        // Three readers: pointer wraps from 2 to requester 0, then becomes 1.
        @(negedge clk); reqValid = 2'b00; r3Valid = 3'b010; s3Ready = 3'b111;
        r3Addrs = {28'd12, 28'd11, 28'd10}; #1;
        chk("r3_first", 128'(r3Ready), 128'(3'b010));
        @(negedge clk); r3Valid = 3'b011; #1;
        chk("r3_wrap", 128'(r3Ready), 128'(3'b001));
        chk("r3_wrap_addr", 128'(m3Addrs), 128'(84'd10));
        chk("r3_rspValid1", 128'(s3Valid), 128'(3'b010));
        chk("r3_rspData1", 128'(s3Data), 128'(32'h5000_000B));
        @(negedge clk); #1;
        chk("r3_ptr1", 128'(r3Ready), 128'(3'b010));
        chk("r3_ptr1_addr", 128'(m3Addrs), 128'(84'd11));
        chk("r3_rspValid0", 128'(s3Valid), 128'(3'b001));
        chk("r3_rspData0", 128'(s3Data), 128'(32'h5000_000A));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
